// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: rPLL dynamic-divider sequencer with debounced lock qualification, timeout retry and a valid/ready config port
module pll_reconfig_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_FILTER  = 8,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         MAX_RETRY    = 3,
  parameter logic [5:0] INIT_IDIV    = 6'd0,
  parameter logic [5:0] INIT_FBDIV   = 6'd2,
  parameter logic [5:0] INIT_ODSEL   = 6'd8
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idiv,
  input  logic [5:0] cfg_fbdiv,
  input  logic [5:0] cfg_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       locked,
  output logic       busy,
  output logic       error,
  output logic [1:0] retry_cnt
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST  = FW'(LOCK_FILTER - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, LOCKED, FAIL} state_t;
  state_t state, state_n;
  logic lock_m, lock_s, accept, error_n;
  logic [RW-1:0] rst_cnt, rst_cnt_n;
  logic [FW-1:0] flt_cnt, flt_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [1:0] retry_n, retry_inc;
  logic [5:0] idsel_n, fbdsel_n, odsel_n;
  always_comb begin
    accept = cfg_valid && cfg_ready;
    retry_inc = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + 2'd1;
    state_n = state;
    rst_cnt_n = '0;
    to_cnt_n = '0;
    flt_cnt_n = '0;
    retry_n = retry_cnt;
    idsel_n = pll_idsel;
    fbdsel_n = pll_fbdsel;
    odsel_n = pll_odsel;
    case (state)
      PLL_RST: begin
        rst_cnt_n = rst_cnt + 1'b1;
        if (rst_cnt == RST_LAST) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        to_cnt_n = to_cnt + 1'b1;
        flt_cnt_n = lock_s ? flt_cnt + 1'b1 : '0;
        // a qualified lock outranks a timeout landing on the same cycle
        if (lock_s && flt_cnt == FLT_LAST) state_n = LOCKED;
        else if (to_cnt == TO_LAST) begin
          retry_n = retry_inc;
          state_n = (retry_inc == RETRY_MAX) ? FAIL : PLL_RST;
        end
      end
      LOCKED: if (!lock_s) begin
        state_n = PLL_RST;
        retry_n = '0;
      end
      default: ;
    endcase
    error_n = error || state_n == FAIL;
    // dividers only ever change together with entry into PLL reset
    if (accept) begin
      state_n = PLL_RST;
      rst_cnt_n = '0;
      retry_n = '0;
      error_n = 1'b0;
      idsel_n = ~cfg_idiv;
      fbdsel_n = ~cfg_fbdiv;
      odsel_n = cfg_odsel;
    end
  end
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      state <= PLL_RST;
      rst_cnt <= '0;
      flt_cnt <= '0;
      to_cnt <= '0;
      retry_cnt <= '0;
      error <= 1'b0;
      pll_reset <= 1'b1;
      busy <= 1'b1;
      cfg_ready <= 1'b0;
      locked <= 1'b0;
      pll_idsel <= ~INIT_IDIV;
      pll_fbdsel <= ~INIT_FBDIV;
      pll_odsel <= INIT_ODSEL;
    end else begin
      {lock_s, lock_m} <= {lock_m, pll_lock};
      state <= state_n;
      rst_cnt <= rst_cnt_n;
      flt_cnt <= flt_cnt_n;
      to_cnt <= to_cnt_n;
      retry_cnt <= retry_n;
      error <= error_n;
      pll_reset <= state_n == PLL_RST;
      busy <= state_n == PLL_RST || state_n == WAIT_LOCK;
      cfg_ready <= state_n == LOCKED || state_n == FAIL;
      locked <= state_n == LOCKED;
      pll_idsel <= idsel_n;
      pll_fbdsel <= fbdsel_n;
      pll_odsel <= odsel_n;
    end
  end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed vectors for the rPLL reconfiguration sequencer
module tb_pll_reconfig_ctrl;
  logic clkin = 1'b0, reset = 1'b1, cfg_valid = 1'b0, pll_lock = 1'b0;
  logic [5:0] cfg_idiv = '0, cfg_fbdiv = '0, cfg_odsel = '0;
  logic cfg_ready, pll_reset, locked, busy, error, lkd;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [1:0] retry_cnt;
  logic [24:0] act;
  int total = 0, bad = 0;
  localparam logic [17:0] S0 = {6'h3F, 6'h3D, 6'h08};
  localparam logic [17:0] S1 = {6'h3E, 6'h3A, 6'h04};
  localparam logic [17:0] S2 = {6'h3D, 6'h3C, 6'h02};
  localparam logic [17:0] S3 = {6'h3C, 6'h38, 6'h01};
  typedef struct {
    logic v;
    logic [5:0] i, f, o;
    logic lk;
    logic [24:0] exp;
  } vec_t;
  vec_t tbl [16];
  always #5 clkin = ~clkin;
  pll_reconfig_ctrl #(
    .RST_CYCLES(4), .LOCK_FILTER(3), .LOCK_TIMEOUT(20), .MAX_RETRY(2)
  ) dut (
    .clkin(clkin), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv), .cfg_odsel(cfg_odsel),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_idsel(pll_idsel),
    .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .locked(locked),
    .busy(busy), .error(error), .retry_cnt(retry_cnt)
  );
  assign act = {pll_reset, busy, cfg_ready, locked, error, retry_cnt, pll_idsel, pll_fbdsel, pll_odsel};
  // flags are {pll_reset, busy, cfg_ready, locked, error}
  function automatic logic [24:0] mk(input logic [4:0] fl, input logic [1:0] rt, input logic [17:0] s);
    return {fl, rt, s};
  endfunction
  task automatic check(input string name, input logic [24:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rst/busy/rdy/lkd/err=%b retry=%0d sel=%h, want %b retry=%0d sel=%h",
               name, act[24:20], act[19:18], act[17:0], exp[24:20], exp[19:18], exp[17:0]);
    end
  endtask
  task automatic step(input logic v, input logic [5:0] i, input logic [5:0] f, input logic [5:0] o, input logic lk);
    cfg_valid = v;
    cfg_idiv = i;
    cfg_fbdiv = f;
    cfg_odsel = o;
    pll_lock = lk;
    @(posedge clkin);
    #1;
  endtask
  task automatic run_row(input int n);
    step(tbl[n].v, tbl[n].i, tbl[n].f, tbl[n].o, tbl[n].lk);
    check($sformatf("row%0d", n + 1), tbl[n].exp);
  endtask
  initial begin
    tbl[0]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b11000, 2'd0, S0)};
    tbl[1]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b11000, 2'd0, S0)};
    tbl[2]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b11000, 2'd0, S0)};
    tbl[3]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b01000, 2'd0, S0)};
    tbl[4]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b01000, 2'd0, S0)};
    tbl[5]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b1, mk(5'b01000, 2'd0, S0)};
    tbl[6]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b1, mk(5'b01000, 2'd0, S0)};
    tbl[7]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b1, mk(5'b01000, 2'd0, S0)};
    tbl[8]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b1, mk(5'b01000, 2'd0, S0)};
    tbl[9]  = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b1, mk(5'b00110, 2'd0, S0)};
    tbl[10] = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b1, mk(5'b00110, 2'd0, S0)};
    tbl[11] = '{1'b1, 6'd1, 6'd5, 6'd4, 1'b1, mk(5'b11000, 2'd0, S1)};
    tbl[12] = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b11000, 2'd0, S1)};
    tbl[13] = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b11000, 2'd0, S1)};
    tbl[14] = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b11000, 2'd0, S1)};
    tbl[15] = '{1'b0, 6'd0, 6'd0, 6'd0, 1'b0, mk(5'b01000, 2'd0, S1)};
    repeat (2) @(posedge clkin);
    #1 check("reset", mk(5'b11000, 2'd0, S0));
    reset = 1'b0;
    // init sequence, first lock, then a request accepted while locked
    for (int n = 0; n < 16; n++) run_row(n);
    // lock stuck low: two 24-cycle attempts then FAIL
    for (int e = 17; e <= 62; e++) begin
      step(1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
      check($sformatf("timeout e%0d", e),
            mk({e >= 36 && e <= 39, e < 60, e >= 60, 1'b0, e >= 60},
               e >= 60 ? 2'd2 : (e >= 36 ? 2'd1 : 2'd0), S1));
    end
    // request from FAIL, one timeout, short lock glitch, lock, lock loss, relock, request racing lock loss
    for (int k = 0; k <= 56; k++) begin
      lkd = (k >= 39 && k <= 43) || (k >= 51 && k <= 54);
      step(k == 0 || k == 55, k == 0 ? 6'd2 : 6'd3, k == 0 ? 6'd3 : 6'd7, k == 0 ? 6'd2 : 6'd1,
           k == 30 || k == 31 || (k >= 35 && k != 42 && k != 53));
      check($sformatf("relock k%0d", k),
            mk({k <= 3 || (k >= 24 && k <= 27) || (k >= 44 && k <= 47) || k >= 55, !lkd, lkd, lkd, 1'b0},
               (k >= 24 && k <= 43) ? 2'd1 : 2'd0, k >= 55 ? S3 : S2));
    end
    // asynchronous reset in the middle of PLL reset for a new request
    #1;
    reset = 1'b1;
    pll_lock = 1'b0;
    cfg_valid = 1'b0;
    #1 check("async reset", mk(5'b11000, 2'd0, S0));
    @(posedge clkin);
    #1 check("reset held", mk(5'b11000, 2'd0, S0));
    reset = 1'b0;
    for (int n = 0; n < 10; n++) run_row(n);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
